// File: rtl/rom_programmer.sv
// ============================================================================
// Module   : rom_programmer
// Brief    : Fuse programmer for 556PT5/556PT4 bipolar PROMs. Burns one word
//            per start: timed per-bit pulses, read-back verify, bounded retry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_programmer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int PULSE_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [3:0]               operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic [DATA_WIDTH-1:0]    program_line,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    failed_bits
);

  localparam logic [3:0] c_op_idle = 4'b1111;
  localparam logic [3:0] c_op_read = 4'b1100;
  localparam logic [3:0] c_op_prog = 4'b0100;

  localparam int TIMER_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int RW        = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_CHECK   = 3'd2,
    S_PULSE   = 3'd3,
    S_RECOVER = 3'd4,
    S_VERIFY  = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic [RW-1:0]         r_retry;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_readback;
  logic [DATA_WIDTH-1:0] r_target_bit;

  logic [DATA_WIDTH-1:0] w_overburn;
  logic [DATA_WIDTH-1:0] w_need;
  logic [DATA_WIDTH-1:0] w_pick;

  // Blown fuses cannot be cleared, so any 1 where the target wants 0 is fatal.
  assign w_overburn = r_readback & ~r_data;
  assign w_need     = r_data & ~r_readback;
  // Two's-complement trick isolates the lowest set bit, keeping the pulse one-hot.
  assign w_pick     = w_need & (~w_need + DATA_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_retry      <= '0;
      r_data       <= '0;
      r_readback   <= '0;
      r_target_bit <= '0;
      operation    <= c_op_idle;
      address_line <= '0;
      program_line <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      failed_bits  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          operation    <= c_op_idle;
          program_line <= '0;
          if (start) begin
            r_data       <= write_data;
            address_line <= write_address;
            error        <= 1'b0;
            failed_bits  <= '0;
            busy         <= 1'b1;
            operation    <= c_op_read;
            r_timer      <= TW'(SETTLE_CYCLES - 1);
            r_state      <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (r_timer == '0) begin
            r_readback <= data_line_in;
            operation  <= c_op_idle;
            r_state    <= S_CHECK;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_CHECK: begin
          if (|w_overburn) begin
            failed_bits <= w_overburn;
            error       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_DONE;
          end else if (w_pick == '0) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_retry      <= '0;
            r_target_bit <= w_pick;
            program_line <= w_pick;
            operation    <= c_op_prog;
            r_timer      <= TW'(PULSE_CYCLES - 1);
            r_state      <= S_PULSE;
          end
        end

        S_PULSE: begin
          if (r_timer == '0) begin
            program_line <= '0;
            operation    <= c_op_read;
            r_timer      <= TW'(SETTLE_CYCLES - 1);
            r_state      <= S_RECOVER;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_RECOVER: begin
          if (r_timer == '0) begin
            r_readback <= data_line_in;
            operation  <= c_op_idle;
            r_state    <= S_VERIFY;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_VERIFY: begin
          if (|(r_readback & r_target_bit)) begin
            r_state <= S_CHECK;
          end else if (r_retry == RW'(MAX_RETRIES - 1)) begin
            failed_bits <= failed_bits | r_target_bit;
            error       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_retry      <= r_retry + RW'(1);
            program_line <= r_target_bit;
            operation    <= c_op_prog;
            r_timer      <= TW'(PULSE_CYCLES - 1);
            r_state      <= S_PULSE;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          operation <= c_op_idle;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_programmer.sv
// ============================================================================
// Module   : tb_rom_programmer
// Brief    : Directed self-checking bench for rom_programmer with a fuse model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_programmer;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam logic [3:0] OPI = 4'b1111;
  localparam logic [3:0] OPR = 4'b1100;
  localparam logic [3:0] OPP = 4'b0100;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] data_line_in;
  logic [3:0]    operation;
  logic [AW-1:0] address_line;
  logic [DW-1:0] program_line;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] failed_bits;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rom_programmer #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .PULSE_CYCLES(4), .SETTLE_CYCLES(2), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .write_address(write_address), .write_data(write_data),
    .data_line_in(data_line_in), .operation(operation),
    .address_line(address_line), .program_line(program_line),
    .busy(busy), .done(done), .error(error), .failed_bits(failed_bits)
  );

  // Chip model: blank bits read 0, a pulse blows the fuse (unless masked as stuck)
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mdl_clear = 1'b0;
  logic          mdl_load = 1'b0;
  logic [AW-1:0] mdl_addr = '0;
  logic [DW-1:0] mdl_val = '0;
  logic [DW-1:0] ignore_mask = '0;

  always @(posedge clk) begin
    if (mdl_clear) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
    end else if (mdl_load) begin
      mem[mdl_addr] <= mdl_val;
    end else if (operation == OPP) begin
      mem[address_line] <= mem[address_line] | (program_line & ~ignore_mask);
    end
  end

  assign data_line_in = (operation == OPR) ? mem[address_line] : '0;

  // Per-operation trace filled by run_op
  logic [DW-1:0] tr_prog [0:299];
  logic [3:0]    tr_op   [0:299];
  int done_at, n_pulses, prog_cycles, read_cycles;
  bit timed_out, multi_hot, busy_bad, addr_bad;

  task automatic load_cell(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    mdl_addr = a; mdl_val = v; mdl_load = 1'b1;
    @(negedge clk);
    mdl_load = 1'b0;
  endtask

  task automatic run_op(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit hold, input logic [AW-1:0] alt_addr,
                        input logic [DW-1:0] alt_data);
    logic [DW-1:0] prev;
    done_at = 0; timed_out = 1'b1; n_pulses = 0; prog_cycles = 0; read_cycles = 0;
    multi_hot = 1'b0; busy_bad = 1'b0; addr_bad = 1'b0; prev = '0;
    @(negedge clk);
    start = 1'b1; write_address = addr; write_data = data;
    for (int n = 1; n < 300; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      else begin write_address = alt_addr; write_data = alt_data; end
      tr_prog[n] = program_line;
      tr_op[n]   = operation;
      if (program_line != '0 && prev == '0) n_pulses++;
      if (program_line != '0) prog_cycles++;
      if ((program_line & (program_line - DW'(1))) != '0) multi_hot = 1'b1;
      if (operation == OPR) read_cycles++;
      if (operation != OPI && address_line !== addr) addr_bad = 1'b1;
      prev = program_line;
      if (done === 1'b1) begin
        done_at = n; timed_out = 1'b0;
        if (busy !== 1'b0) busy_bad = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1; mdl_clear = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({operation, address_line, program_line, busy, done, error, failed_bits} !==
        {OPI, 9'h000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: op=%b addr=%h prog=%h busy=%b done=%b err=%b fb=%h required op=1111 rest 0",
               operation, address_line, program_line, busy, done, error, failed_bits);
    end
    reset_n = 1'b0; mdl_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_blank_zero();
    run_op(9'h1A5, 8'h00, 1'b0, '0, '0);
    n_checks++; if (timed_out || done_at !== 4) begin n_fail++; $display("FAIL zero_latency: got %0d (timeout=%0d) required 4", done_at, timed_out); end
    n_checks++; if (n_pulses !== 0) begin n_fail++; $display("FAIL zero_pulses: got %0d required 0", n_pulses); end
    n_checks++; if (read_cycles !== 2 || tr_op[1] !== OPR || tr_op[2] !== OPR) begin n_fail++; $display("FAIL zero_read_window: reads=%0d op1=%b op2=%b required 2 reads in cycles 1-2", read_cycles, tr_op[1], tr_op[2]); end
    n_checks++; if (error !== 1'b0 || failed_bits !== 8'h00) begin n_fail++; $display("FAIL zero_result: err=%b fb=%h required 0/00", error, failed_bits); end
    n_checks++; if (busy_bad) begin n_fail++; $display("FAIL zero_busy: busy not high until done, got bad=1 required 0"); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: done=%b required 0", done); end
  endtask

  task automatic test_two_bits();
    int bad;
    run_op(9'h003, 8'h81, 1'b0, '0, '0);
    bad = 0;
    for (int n = 4; n <= 7; n++)   if (tr_prog[n] !== 8'h01 || tr_op[n] !== OPP) bad++;
    for (int n = 12; n <= 15; n++) if (tr_prog[n] !== 8'h80 || tr_op[n] !== OPP) bad++;
    for (int n = 8; n <= 9; n++)   if (tr_prog[n] !== 8'h00 || tr_op[n] !== OPR) bad++;
    for (int n = 16; n <= 17; n++) if (tr_prog[n] !== 8'h00 || tr_op[n] !== OPR) bad++;
    n_checks++; if (timed_out || done_at !== 20) begin n_fail++; $display("FAIL two_latency: got %0d required 20", done_at); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL two_sequence: bad cycles %0d required 0", bad); end
    n_checks++; if (n_pulses !== 2 || prog_cycles !== 8 || multi_hot) begin n_fail++; $display("FAIL two_pulses: pulses=%0d cycles=%0d multihot=%0d required 2/8/0", n_pulses, prog_cycles, multi_hot); end
    n_checks++; if (error !== 1'b0 || mem[9'h003] !== 8'h81) begin n_fail++; $display("FAIL two_result: err=%b word=%h required 0/81", error, mem[9'h003]); end
  endtask

  task automatic test_stuck_bit();
    @(negedge clk); ignore_mask = 8'h04;
    run_op(9'h010, 8'h04, 1'b0, '0, '0);
    n_checks++; if (timed_out || done_at !== 25) begin n_fail++; $display("FAIL stuck_latency: got %0d required 25", done_at); end
    n_checks++; if (n_pulses !== 3 || prog_cycles !== 12) begin n_fail++; $display("FAIL stuck_pulses: pulses=%0d cycles=%0d required 3/12", n_pulses, prog_cycles); end
    n_checks++; if (error !== 1'b1 || failed_bits !== 8'h04) begin n_fail++; $display("FAIL stuck_result: err=%b fb=%h required 1/04", error, failed_bits); end
    ignore_mask = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++; if (error !== 1'b1 || failed_bits !== 8'h04 || done !== 1'b0) begin n_fail++; $display("FAIL stuck_hold: err=%b fb=%h done=%b required 1/04/0", error, failed_bits, done); end
  endtask

  task automatic test_overburn();
    load_cell(9'h020, 8'h10);
    run_op(9'h020, 8'h01, 1'b0, '0, '0);
    n_checks++; if (timed_out || done_at !== 4 || n_pulses !== 0) begin n_fail++; $display("FAIL over_timing: done_at=%0d pulses=%0d required 4/0", done_at, n_pulses); end
    n_checks++; if (error !== 1'b1 || failed_bits !== 8'h10) begin n_fail++; $display("FAIL over_result: err=%b fb=%h required 1/10", error, failed_bits); end
  endtask

  task automatic test_reset_mid_pulse();
    bit seen, done_seen;
    seen = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; write_address = 9'h040; write_data = 8'h02;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (program_line != '0) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_pulse_start: pulse seen=0 required 1"); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (program_line !== 8'h00 || operation !== OPI || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_outputs: prog=%h op=%b busy=%b done=%b required 00/1111/0/0", program_line, operation, busy, done); end
    reset_n = 1'b0;
    repeat (8) begin @(negedge clk); if (done === 1'b1) done_seen = 1'b1; end
    n_checks++; if (done_seen) begin n_fail++; $display("FAIL rst_no_done: done pulse seen=1 required 0"); end
    run_op(9'h041, 8'h02, 1'b0, '0, '0);
    n_checks++; if (timed_out || done_at !== 12 || n_pulses !== 1) begin n_fail++; $display("FAIL rst_reprog_timing: done_at=%0d pulses=%0d required 12/1", done_at, n_pulses); end
    n_checks++; if (error !== 1'b0 || mem[9'h041] !== 8'h02 || tr_prog[4] !== 8'h02) begin n_fail++; $display("FAIL rst_reprog_result: err=%b word=%h prog=%h required 0/02/02", error, mem[9'h041], tr_prog[4]); end
  endtask

  task automatic test_back_to_back();
    bit fin;
    run_op(9'h050, 8'h03, 1'b1, 9'h051, 8'hFF);
    n_checks++; if (timed_out || done_at !== 20 || addr_bad) begin n_fail++; $display("FAIL b2b_first: done_at=%0d addr_bad=%0d required 20/0", done_at, addr_bad); end
    n_checks++; if (mem[9'h050] !== 8'h03 || mem[9'h051] !== 8'h00 || error !== 1'b0) begin n_fail++; $display("FAIL b2b_word: w50=%h w51=%h err=%b required 03/00/0", mem[9'h050], mem[9'h051], error); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy=%b required 0", busy); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1 || address_line !== 9'h051 || operation !== OPR) begin n_fail++; $display("FAIL b2b_second_start: busy=%b addr=%h op=%b required 1/051/1100", busy, address_line, operation); end
    fin = 1'b0;
    for (int n = 0; n < 300 && !fin; n++) begin
      @(negedge clk);
      if (done === 1'b1) fin = 1'b1;
    end
    n_checks++; if (!fin || error !== 1'b0 || mem[9'h051] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: done=%0d err=%b word=%h required 1/0/FF", fin, error, mem[9'h051]); end
  endtask

  initial begin
    test_reset();
    test_blank_zero();
    test_two_bits();
    test_stuck_bit();
    test_overburn();
    test_reset_mid_pulse();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/rom_programmer.md
Name: rom_programmer

Overview:
- Fuse programmer for 556PT5 (3604, 512x8) and 556PT4 (3601, 256x4) bipolar PROMs; the write-side counterpart of the team's ROM reader.
- Burns one word per start request, bit by bit: timed fuse pulses, read-back verify, bounded retries.
- Sits between host/control logic and the chip socket; drives address, operation and per-bit program lines, and reads back the chip data outputs.

Parameters:
- DATA_WIDTH, 8, chip data width (4 for 3601).
- ADDRESS_WIDTH, 9, chip address width (8 for 3601).
- PULSE_CYCLES, 16, clk cycles per fuse pulse (>=1).
- SETTLE_CYCLES, 4, clk cycles of read settling before any sample (>=1).
- MAX_RETRIES, 3, pulses allowed per bit before failure (>=1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-high (1 = reset)
- start  in  1  request to program one word; sampled only in IDLE
- write_address  in  ADDRESS_WIDTH  target address, latched on accepted start
- write_data  in  DATA_WIDTH  target word, latched on accepted start
- data_line_in  in  DATA_WIDTH  chip data outputs (read-back)
- operation  out  4  chip control V1..V4 (bit0 = V1)
- address_line  out  ADDRESS_WIDTH  chip address
- program_line  out  DATA_WIDTH  one-hot fuse-pulse enable per data bit
- busy  out  1  high from accept until DONE exits
- done  out  1  one-cycle completion pulse
- error  out  1  result flag, valid from done; held until next accepted start
- failed_bits  out  DATA_WIDTH  bits that could not be made to match; held like error

Behaviour:
- Operation codes: OP_IDLE = 4'b1111 (chip deselected), OP_READ = 4'b1100, OP_PROG = 4'b0100.
- Bit model: blank bit reads 0; a pulse sets it to 1; 1 -> 0 is impossible.
- Reset values (sync reset wins over everything): state IDLE, operation OP_IDLE, address_line 0, program_line 0, busy 0, done 0, error 0, failed_bits 0, retry counter 0, timer 0.
- Timer: timed states load the timer with N-1 on entry and exit when it reaches 0, so each lasts exactly N cycles.
- IDLE: operation OP_IDLE, program_line 0. start=1 -> latch address/data, clear error/failed_bits, go SETUP. busy=1 from the next cycle.
- SETUP (SETTLE_CYCLES): operation OP_READ, address_line = latched address. On the last cycle sample data_line_in into readback.
- CHECK (1 cycle):
  - Any bit with readback=1 and target=0 -> failed_bits = those bits, error=1, go DONE.
  - Else pick the lowest-index bit i with target=1 and readback=0; none -> go DONE with error=0.
  - Else retry=0, go PULSE.
- PULSE (PULSE_CYCLES): operation OP_PROG, program_line = one-hot bit i; address held. program_line is never multi-hot and is never nonzero outside PULSE.
- RECOVER (SETTLE_CYCLES): program_line 0, operation OP_READ. Sample data_line_in on the last cycle.
- VERIFY (1 cycle):
  - Bit i now 1 -> go CHECK, which selects the next bit.
  - Else retry+1; if retry+1 = MAX_RETRIES -> failed_bits[i]=1, error=1, go DONE.
  - Else go PULSE.
  - Any other bit that read back differently from the previous sample is ignored here; CHECK re-evaluates it.
- DONE (1 cycle): done=1, operation OP_IDLE, busy=0 (busy is asserted through the last non-DONE cycle); go IDLE.
- start during any non-IDLE state is ignored; write_address/write_data changes mid-operation have no effect.
- Reset mid-PULSE: program_line=0 and operation=OP_IDLE from the cycle after the reset edge; no done pulse.
- Address range: write_address is used as-is. For a 3601 the top-level ties ADDRESS_WIDTH=8, so there is no wrap logic here.
- Latency for an already-matching word: done asserted SETTLE_CYCLES+2 cycles after the accepting edge.

Test Plan:
- Bench params PULSE_CYCLES=4, SETTLE_CYCLES=2, MAX_RETRIES=3, chip model with per-bit fuses.
- Blank chip, start addr 9'h1A5, data 8'h00 -> no program_line activity; done 4 cycles after accept; error=0; operation OP_READ only during SETUP.
- Blank chip, addr 9'h003, data 8'h81 -> program_line = 8'h01 for 4 cycles, then 8'h80 for 4 cycles, each followed by 2 OP_READ cycles; done with error=0; model word 8'h81.
- Model ignores pulses on bit 2, data 8'h04 -> exactly 3 pulses on 8'h04; done with error=1, failed_bits=8'h04.
- Cell preloaded 8'h10, data 8'h01 -> no pulses at all; done with error=1, failed_bits=8'h10.
- Assert reset_n on cycle 2 of a PULSE -> next cycle program_line=0, operation=4'b1111, busy=0; no done pulse. Then a new start programs 8'h02 successfully.
- start held high through a whole operation with changing write_data -> only the first word is programmed. A second operation begins on the IDLE cycle after done.
